// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq: read-side sequencer for the weight RAM; streams N-wide rows to the MAC array.
// Optional build macro WFS_CHECKSUM_EN adds a running 16-bit weight checksum output (csum).
`timescale 1ns/1ps
module weight_fetch_seq #(
  parameter int N      = 10,
  parameter int W      = 10,
  parameter int AW     = 7,
  parameter int DEPTH  = 65,
  parameter int RW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [RW-1:0] rows,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_in,
  input  logic [W-1:0]  ram_q [0:N-1],
  output logic [W-1:0]  out_vec [0:N-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_idx
`ifdef WFS_CHECKSUM_EN
  ,
  output logic [15:0]   csum
`endif
);

  // Wide enough that Base + Rows*N - 1 can never wrap for any input.
  localparam int EW = AW + RW + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_FIN
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   base_reg;
  logic [RW-1:0]   rows_reg;
  logic [RW-1:0]   row_reg;
  logic [1:0]      lat_cnt_reg;

  logic [EW-1:0]   end_addr;
  logic            in_range;
  logic            capture;
  logic            handshake;

  assign ram_we = 1'b0;
  assign ram_in = 1'b0;

  always_comb begin
    end_addr  = EW'(base) + EW'(rows) * EW'(N) - EW'(1);
    in_range  = (end_addr <= EW'(DEPTH - 1));
    // The RAM needs RD_LAT cycles after the address register changes; sample one edge later.
    capture   = (state_reg == S_WAIT) && (lat_cnt_reg == 2'(RD_LAT));
    handshake = (state_reg == S_HOLD) && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      base_reg    <= '0;
      rows_reg    <= '0;
      row_reg     <= '0;
      lat_cnt_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ram_addr    <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (rows == '0) begin
              busy      <= 1'b1;
              state_reg <= S_FIN;
            end else if (!in_range) begin
              err <= 1'b1;
            end else begin
              base_reg  <= base;
              rows_reg  <= rows;
              row_reg   <= '0;
              busy      <= 1'b1;
              state_reg <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ram_addr    <= AW'(EW'(base_reg) + EW'(row_reg) * EW'(N));
          lat_cnt_reg <= '0;
          state_reg   <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            out_idx   <= row_reg;
            out_valid <= 1'b1;
            state_reg <= S_HOLD;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        S_HOLD: begin
          // Single-entry buffer: the next read is only issued once this vector is taken.
          if (handshake) begin
            out_valid <= 1'b0;
            if (row_reg == rows_reg - RW'(1)) begin
              state_reg <= S_FIN;
            end else begin
              row_reg   <= row_reg + RW'(1);
              state_reg <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        out_vec[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < N; i++) begin
        out_vec[i] <= ram_q[i];
      end
    end
  end

`ifdef WFS_CHECKSUM_EN
  logic [15:0] lane_ext [0:N-1];
  logic [15:0] vec_sum;
  logic        start_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane_ext
    assign lane_ext[gi] = 16'(out_vec[gi]);
  end

  always_comb begin
    vec_sum = '0;
    for (int i = 0; i < N; i++) begin
      vec_sum = vec_sum + lane_ext[i];
    end
    start_ok = (state_reg == S_IDLE) && start && ((rows == '0) || in_range);
  end

  // Accumulates modulo 2^16; a rejected Start leaves the previous result intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (handshake) begin
      csum <= csum + vec_sum;
    end
  end
`endif

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Directed bench for weight_fetch_seq: flat RAM image where each weight equals its own address.
`timescale 1ns/1ps
module tb_weight_fetch_seq;

  localparam int N      = 10;
  localparam int W      = 10;
  localparam int AW     = 7;
  localparam int DEPTH  = 65;
  localparam int RW     = 4;
  localparam int RD_LAT = 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [RW-1:0] rows;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_in;
  logic [W-1:0]  ram_q [0:N-1];
  logic [W-1:0]  out_vec [0:N-1];
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_idx;
`ifdef WFS_CHECKSUM_EN
  logic [15:0]   csum;
`endif

  int checks = 0;
  int errors = 0;

  weight_fetch_seq #(
    .N(N), .W(W), .AW(AW), .DEPTH(DEPTH), .RW(RW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base(base),
    .rows(rows),
    .busy(busy),
    .done(done),
    .err(err),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_in(ram_in),
    .ram_q(ram_q),
    .out_vec(out_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx)
`ifdef WFS_CHECKSUM_EN
    ,
    .csum(csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model: lane i of the row at address A holds A+i.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      ram_q[i] <= W'(int'(ram_addr) + i);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int r);
    base  = AW'(b);
    rows  = RW'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid_timeout"}, int'(n >= 50), 0);
  endtask

  // Consumes vectors from the current sample onward until Done, checking every row.
  task automatic collect(input string tag, input int b, input int r);
    int got;
    int dn;
    int cyc;
    got = 0;
    dn  = 0;
    cyc = 0;
    while (dn == 0 && cyc < 300) begin
      if (out_valid && out_ready) begin
        check({tag, "_idx"}, int'(out_idx), got);
        check({tag, "_addr"}, int'(ram_addr), b + got * N);
        for (int i = 0; i < N; i++) begin
          check({tag, "_lane"}, int'(out_vec[i]), b + got * N + i);
        end
        $display("row %s idx=%0d addr=%0d lane0=%0d", tag, out_idx, ram_addr, out_vec[0]);
        got++;
      end
      if (done) begin
        dn++;
        check({tag, "_busy_at_done"}, int'(busy), 0);
      end
      tick();
      cyc++;
    end
    check({tag, "_rows"}, got, r);
    for (int k = 0; k < 3; k++) begin
      if (done) dn++;
      tick();
    end
    check({tag, "_done_cnt"}, dn, 1);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_addr"}, int'(ram_addr), 0);
    check({tag, "_idx"}, int'(out_idx), 0);
    check({tag, "_vec0"}, int'(out_vec[0]), 0);
    check({tag, "_vec9"}, int'(out_vec[N-1]), 0);
    check({tag, "_we"}, int'(ram_we), 0);
    check({tag, "_in"}, int'(ram_in), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int addr_before;
    rst       = 1'b1;
    start     = 1'b0;
    base      = '0;
    rows      = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: Base=0, Rows=3, ready tied high; first vector RD_LAT+2 cycles after Start.
    do_start(0, 3);
    check("t1_busy", int'(busy), 1);
    wait_valid("t1", n);
    check("t1_latency", n, RD_LAT + 2);
    collect("t1", 0, 3);
`ifdef WFS_CHECKSUM_EN
    check("t1_csum", int'(csum), 435);
`endif

    // 2: End = 69 > 64 is rejected with a one-cycle Err.
    addr_before = int'(ram_addr);
    do_start(40, 3);
    check("t2_err", int'(err), 1);
    check("t2_busy", int'(busy), 0);
    check("t2_valid", int'(out_valid), 0);
    check("t2_addr", int'(ram_addr), addr_before);
    tick();
    check("t2_err_fall", int'(err), 0);
    check("t2_busy2", int'(busy), 0);
    $display("req base=40 rows=3 rejected");

    // 3: End = 64 exactly is the last legal row.
    do_start(35, 3);
    check("t3_err", int'(err), 0);
    wait_valid("t3", n);
    collect("t3", 35, 3);

    // 4: consumer stalls for 20 cycles; a Start while busy must be ignored.
    out_ready = 1'b0;
    do_start(20, 2);
    wait_valid("t4", n);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      base  = '0;
      rows  = RW'(1);
      if (!out_valid || out_idx != 0 || out_vec[0] != 20 || out_vec[N-1] != 29
          || ram_addr != 20 || err || done) bad++;
      tick();
    end
    start = 1'b0;
    check("t4_stall_stable", bad, 0);
    $display("stall base=20 held %0d cycles", 20);
    out_ready = 1'b1;
    collect("t4", 20, 2);

    // 5: reset while holding row 1 of 3, then a clean restart.
    out_ready = 1'b0;
    do_start(10, 3);
    wait_valid("t5a", n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("t5b", n);
    check("t5_idx_before_rst", int'(out_idx), 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    #2 rst = 1'b0;
    tick();
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy || out_valid) bad++;
      tick();
    end
    check("t5_no_done", bad, 0);
    out_ready = 1'b1;
    do_start(10, 3);
    wait_valid("t5c", n);
    collect("t5", 10, 3);

    // 6: single row checksum, then the Rows=0 no-op.
    do_start(0, 1);
    wait_valid("t6", n);
    collect("t6", 0, 1);
`ifdef WFS_CHECKSUM_EN
    check("t6_csum45", int'(csum), 45);
`endif
    do_start(5, 0);
    check("t6_noop_busy", int'(busy), 1);
    check("t6_noop_done_early", int'(done), 0);
    tick();
    check("t6_noop_done", int'(done), 1);
    check("t6_noop_busy_fall", int'(busy), 0);
    check("t6_noop_valid", int'(out_valid), 0);
    tick();
    check("t6_noop_done_fall", int'(done), 0);
`ifdef WFS_CHECKSUM_EN
    check("t6_csum0", int'(csum), 0);
`endif
    $display("noop rows=0 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
